// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter with a Wishbone classic register port.
// Bytes written to TXDATA are queued in a FIFO and sent LSB first.
// Frame format, divisor, parity and stop bits come from CONFIG and are
// latched when each frame is loaded.
module uart_tx_fifo #(
  parameter int DAT_WIDTH   = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 868
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [1:0]  adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        uart_tx,
  output logic        irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

  logic                 rst_meta, rst_sync_n;
  logic                 req, ack_q, ack_d, push, push_ok, pop, load, cfg_wr;
  logic [31:0]          dat_q, rd_data;
  logic [DAT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count_q, count_d;
  logic                 fifo_empty, fifo_full, busy;
  logic [DIV_WIDTH-1:0] div_q, div_eff, cur_div_q, baud_q, baud_d;
  logic                 par_en_q, par_odd_q, two_stop_q;
  logic                 cur_par_en_q, cur_two_stop_q, par_bit_q, par_bit_d;
  tx_state_e            state_q, state_d;
  logic [3:0]           bit_q, bit_d;
  logic [DAT_WIDTH-1:0] shift_q, shift_d, head;
  logic                 tx_q, tx_d, bit_end;
  logic                 unused_dat;

  assign unused_dat = ^dat_i;

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) {rst_meta, rst_sync_n} <= 2'b00;
    else         {rst_meta, rst_sync_n} <= {1'b1, rst_meta};
  end

  assign req        = cyc_i && stb_i;
  assign ack_o      = ack_q && req;
  assign dat_o      = dat_q;
  assign push       = ack_o && we_i && (adr_i == 2'd0);
  assign cfg_wr     = ack_o && we_i && (adr_i == 2'd2);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign push_ok    = push && (!fifo_full || pop);
  assign count_d    = count_q + CW'(push_ok) - CW'(pop);
  assign busy       = (state_q != IDLE);
  assign irq_o      = fifo_empty && !busy;
  assign uart_tx    = tx_q;
  assign head       = mem[rd_ptr];
  assign div_eff    = (div_q < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div_q;
  assign bit_end    = (baud_q == cur_div_q - DIV_WIDTH'(1));

  // Ack is granted a cycle after the request; a TXDATA write waits while the FIFO stays full.
  assign ack_d = req && !ack_q && !(we_i && (adr_i == 2'd0) && (count_d == CW'(FIFO_DEPTH)));

  // Read data mux, captured together with the ack decision.
  always_comb begin
    rd_data = '0;
    case (adr_i)
      2'd1: begin
        rd_data[0]    = busy;
        rd_data[1]    = fifo_empty;
        rd_data[2]    = fifo_full;
        rd_data[15:8] = 8'(count_q);
      end
      2'd2: begin
        rd_data[DIV_WIDTH-1:0] = div_q;
        rd_data[16]            = par_en_q;
        rd_data[17]            = par_odd_q;
        rd_data[18]            = two_stop_q;
      end
      default: rd_data = '0;
    endcase
  end

  // Wishbone ack/data registers and the CONFIG register.
  always_ff @(posedge clk_i or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      div_q      <= DIV_WIDTH'(DEFAULT_DIV);
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
      dat_q <= (ack_d && !we_i) ? rd_data : '0;
      if (cfg_wr) begin
        div_q      <= dat_i[DIV_WIDTH-1:0];
        par_en_q   <= dat_i[16];
        par_odd_q  <= dat_i[17];
        two_stop_q <= dat_i[18];
      end
    end
  end

  // FIFO storage needs no reset; the level and pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= dat_i[DAT_WIDTH-1:0];
  end

  // FIFO pointers and level.
  always_ff @(posedge clk_i or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_d;
    end
  end

  // Transmitter next state, datapath and registered serial output.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    load      = 1'b0;
    shift_d   = shift_q;
    bit_d     = bit_q;
    par_bit_d = par_bit_q;
    baud_d    = (state_q == IDLE || bit_end) ? '0 : baud_q + DIV_WIDTH'(1);
    case (state_q)
      IDLE:   if (!fifo_empty) load = 1'b1;
      START:  if (bit_end) begin
                state_d = DATA;
                bit_d   = '0;
              end
      DATA:   if (bit_end) begin
                shift_d = shift_q >> 1;
                if (bit_q == 4'(DAT_WIDTH - 1)) begin
                  state_d = cur_par_en_q ? PARITY : STOP;
                  bit_d   = '0;
                end else begin
                  bit_d = bit_q + 4'd1;
                end
              end
      PARITY: if (bit_end) begin
                state_d = STOP;
                bit_d   = '0;
              end
      STOP:   if (bit_end) begin
                if (bit_q == {3'b000, cur_two_stop_q}) begin
                  if (!fifo_empty) load = 1'b1;
                  else             state_d = IDLE;
                end else begin
                  bit_d = bit_q + 4'd1;
                end
              end
      default: state_d = IDLE;
    endcase
    if (load) begin
      pop       = 1'b1;
      state_d   = START;
      shift_d   = head;
      bit_d     = '0;
      baud_d    = '0;
      par_bit_d = (^head) ^ par_odd_q;
    end
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit_q;
      default: tx_d = 1'b1;
    endcase
  end

  // Transmitter state register; frame settings are latched at load.
  always_ff @(posedge clk_i or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q        <= IDLE;
      baud_q         <= '0;
      bit_q          <= '0;
      shift_q        <= '0;
      par_bit_q      <= 1'b0;
      tx_q           <= 1'b1;
      cur_div_q      <= DIV_WIDTH'(2);
      cur_par_en_q   <= 1'b0;
      cur_two_stop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      if (load) begin
        cur_div_q      <= div_eff;
        cur_par_en_q   <= par_en_q;
        cur_two_stop_q <= two_stop_q;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: register access, frame timing,
// parity/stop options, FIFO stall, reset abort and a 5-bit build.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cyc_a = 1'b0, cyc_b = 1'b0, stb = 1'b0, we = 1'b0;
  logic [1:0]  adr = 2'd0;
  logic [31:0] wdat = '0;
  logic [31:0] dat_a, dat_b;
  logic        ack_a, ack_b, tx_a, tx_b, irq_a, irq_b;
  int          cyc_cnt = 0;
  int          tests = 0;
  int          fails = 0;

  uart_tx_fifo dut_a (
    .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc_a), .stb_i(stb), .we_i(we),
    .adr_i(adr), .dat_i(wdat), .dat_o(dat_a), .ack_o(ack_a),
    .uart_tx(tx_a), .irq_o(irq_a)
  );

  uart_tx_fifo #(.DAT_WIDTH(5)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc_b), .stb_i(stb), .we_i(we),
    .adr_i(adr), .dat_i(wdat), .dat_o(dat_b), .ack_o(ack_b),
    .uart_tx(tx_b), .irq_o(irq_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s at cycle %0d: observed %h expected %h", tag, cyc_cnt, obs, exp);
    end
  endtask

  task automatic wait_cycle(input int n);
    if (cyc_cnt > n) begin
      tests++;
      fails++;
      $error("[TB] FAIL schedule: observed cycle %0d expected at most %0d", cyc_cnt, n);
    end
    while (cyc_cnt < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One Wishbone transfer; returns ack cycle, cycles waited and read data.
  task automatic apply_stimulus(input bit sel, input bit wr, input logic [1:0] a,
                                input logic [31:0] d, output int ack_cyc,
                                output int lat, output logic [31:0] rdat);
    we = wr; adr = a; wdat = d; stb = 1'b1;
    if (sel) cyc_b = 1'b1; else cyc_a = 1'b1;
    lat = 0; ack_cyc = -1; rdat = '0;
    while (ack_cyc < 0 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if ((sel ? ack_b : ack_a) === 1'b1) begin
        ack_cyc = cyc_cnt;
        rdat    = sel ? dat_b : dat_a;
      end
    end
    if (ack_cyc < 0) begin
      tests++;
      fails++;
      $error("[TB] FAIL ack_timeout: observed no ack in %0d cycles, expected an ack", lat);
    end else begin
      @(posedge clk);
      #1;
      check_output("ack_pulse", 32'(sel ? ack_b : ack_a), 32'd0);
    end
    cyc_a = 1'b0; cyc_b = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic check_tx_at(input bit sel, input int n, input logic exp, input string tag);
    wait_cycle(n);
    check_output(tag, 32'(sel ? tx_b : tx_a), 32'(exp));
  endtask

  task automatic check_irq_at(input bit sel, input int n, input logic exp, input string tag);
    wait_cycle(n);
    check_output(tag, 32'(sel ? irq_b : irq_a), 32'(exp));
  endtask

  task automatic wait_idle(input bit sel);
    int k = 0;
    while ((sel ? irq_b : irq_a) !== 1'b1 && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 3000) begin
      tests++;
      fails++;
      $error("[TB] FAIL idle_timeout: observed irq %b, expected 1", sel ? irq_b : irq_a);
    end
  endtask

  initial begin
    int          a, a0, lat;
    logic [31:0] rd;
    logic [7:0]  b;
    logic [31:0] cfgs [3];
    logic        par_exp [3];
    int          stop_len [3];

    // Reset values
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_tx", 32'(tx_a), 32'd1);
    check_output("rst_ack", 32'(ack_a), 32'd0);
    check_output("rst_dat", dat_a, 32'd0);
    check_output("rst_irq", 32'(irq_a), 32'd1);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    apply_stimulus(0, 0, 2'd2, 32'd0, a, lat, rd);
    check_output("cfg_default", rd, 32'd868);
    apply_stimulus(0, 0, 2'd1, 32'd0, a, lat, rd);
    check_output("status_reset", rd, 32'h0000_0002);
    apply_stimulus(0, 0, 2'd0, 32'd0, a, lat, rd);
    check_output("txdata_read", rd, 32'd0);

    // 8N1 frame of 0xA5 at divisor 4
    apply_stimulus(0, 1, 2'd2, 32'h0000_0004, a, lat, rd);
    check_output("irq_idle", 32'(irq_a), 32'd1);
    b = 8'hA5;
    apply_stimulus(0, 1, 2'd0, 32'(b), a, lat, rd);
    check_output("ack_latency", 32'(lat), 32'd1);
    check_tx_at(0, a + 1, 1'b1, "tx_before_start");
    check_tx_at(0, a + 2, 1'b0, "start_first");
    check_output("irq_busy", 32'(irq_a), 32'd0);
    check_tx_at(0, a + 5, 1'b0, "start_last");
    for (int k = 0; k < 8; k++) check_tx_at(0, a + 6 + 4 * k, b[k], "data_bit");
    check_tx_at(0, a + 38, 1'b1, "stop_first");
    check_tx_at(0, a + 41, 1'b1, "stop_last");
    check_output("irq_in_stop", 32'(irq_a), 32'd0);
    check_irq_at(0, a + 42, 1'b1, "irq_after_stop");

    // Parity and stop-bit options with 0x07
    cfgs[0] = 32'h0001_0004; par_exp[0] = 1'b1; stop_len[0] = 4;
    cfgs[1] = 32'h0003_0004; par_exp[1] = 1'b0; stop_len[1] = 4;
    cfgs[2] = 32'h0007_0004; par_exp[2] = 1'b0; stop_len[2] = 8;
    for (int v = 0; v < 3; v++) begin
      wait_idle(0);
      apply_stimulus(0, 1, 2'd2, cfgs[v], a, lat, rd);
      apply_stimulus(0, 1, 2'd0, 32'h07, a, lat, rd);
      check_tx_at(0, a + 37, 1'b0, "par_last_data");
      check_tx_at(0, a + 38, par_exp[v], "par_bit_first");
      check_tx_at(0, a + 41, par_exp[v], "par_bit_last");
      check_tx_at(0, a + 42, 1'b1, "par_stop");
      check_irq_at(0, a + 41 + stop_len[v], 1'b0, "par_stop_end");
      check_irq_at(0, a + 42 + stop_len[v], 1'b1, "par_idle");
    end

    // Seventeen back-to-back writes fill the FIFO; the eighteenth stalls
    wait_idle(0);
    apply_stimulus(0, 1, 2'd2, 32'h0000_0004, a, lat, rd);
    a0 = 0;
    for (int k = 0; k < 17; k++) begin
      apply_stimulus(0, 1, 2'd0, 32'(8'(k) ^ 8'h55), a, lat, rd);
      if (k == 0) a0 = a;
    end
    check_output("burst_ack16", 32'(a - a0), 32'd32);
    apply_stimulus(0, 0, 2'd1, 32'd0, a, lat, rd);
    check_output("status_full", rd, 32'h0000_1005);
    apply_stimulus(0, 1, 2'd0, 32'h0000_00AA, a, lat, rd);
    check_output("stall_ack", 32'(a - a0), 32'd42);
    check_tx_at(0, a0 + 81, 1'b1, "contig_stop");
    check_tx_at(0, a0 + 82, 1'b0, "contig_start");
    check_tx_at(0, a0 + 86, 1'b1, "byte2_bit0");
    check_tx_at(0, a0 + 98, 1'b0, "byte2_bit3");

    // Asynchronous reset in the middle of a data bit, with a read being acked
    adr = 2'd1; we = 1'b0; stb = 1'b1; cyc_a = 1'b1;
    wait_cycle(a0 + 99);
    check_output("ack_before_rst", 32'(ack_a), 32'd1);
    check_output("tx_before_rst", 32'(tx_a), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_abort_tx", 32'(tx_a), 32'd1);
    check_output("rst_abort_ack", 32'(ack_a), 32'd0);
    cyc_a = 1'b0; stb = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    apply_stimulus(0, 0, 2'd1, 32'd0, a, lat, rd);
    check_output("status_after_rst", rd, 32'h0000_0002);
    apply_stimulus(0, 0, 2'd2, 32'd0, a, lat, rd);
    check_output("cfg_after_rst", rd, 32'd868);
    check_output("tx_after_rst", 32'(tx_a), 32'd1);

    // Divisor change mid-frame applies to the next frame only
    apply_stimulus(0, 1, 2'd2, 32'h0000_0004, a, lat, rd);
    apply_stimulus(0, 1, 2'd0, 32'h0000_0000, a, lat, rd);
    apply_stimulus(0, 1, 2'd2, 32'h0000_0008, a0, lat, rd);
    apply_stimulus(0, 1, 2'd0, 32'h0000_00FF, a0, lat, rd);
    check_tx_at(0, a + 37, 1'b0, "div4_last_data");
    check_tx_at(0, a + 38, 1'b1, "div4_stop");
    check_tx_at(0, a + 41, 1'b1, "div4_stop_end");
    check_tx_at(0, a + 42, 1'b0, "div8_start");
    check_tx_at(0, a + 49, 1'b0, "div8_start_end");
    check_tx_at(0, a + 50, 1'b1, "div8_bit0");

    // Divisor 0 is stored but runs at 2 clocks per bit
    wait_idle(0);
    apply_stimulus(0, 1, 2'd2, 32'h0000_0000, a, lat, rd);
    apply_stimulus(0, 0, 2'd2, 32'd0, a, lat, rd);
    check_output("cfg_div0", rd, 32'd0);
    apply_stimulus(0, 1, 2'd0, 32'h0000_0001, a, lat, rd);
    check_tx_at(0, a + 3, 1'b0, "div2_start");
    check_tx_at(0, a + 4, 1'b1, "div2_bit0");
    check_tx_at(0, a + 5, 1'b1, "div2_bit0_end");
    check_tx_at(0, a + 6, 1'b0, "div2_bit1");

    // Five-bit build: 0x1F gives 7 bit times
    apply_stimulus(1, 1, 2'd2, 32'h0000_0004, a, lat, rd);
    apply_stimulus(1, 1, 2'd0, 32'h0000_001F, a, lat, rd);
    check_output("w5_ack_latency", 32'(lat), 32'd1);
    check_tx_at(1, a + 2, 1'b0, "w5_start");
    check_tx_at(1, a + 5, 1'b0, "w5_start_end");
    check_tx_at(1, a + 6, 1'b1, "w5_bit0");
    check_tx_at(1, a + 25, 1'b1, "w5_bit4");
    check_irq_at(1, a + 29, 1'b0, "w5_stop_end");
    check_irq_at(1, a + 30, 1'b1, "w5_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
